// File: rtl/trig_lockout_gate.sv
// trig_lockout_gate: synchronizes an async trigger, forwards accepted rising edges as
// one-cycle pulses and rejects (counts) edges that land inside the post-trigger lockout window.
module trig_lockout_gate #(
    parameter int SYNC_DEPTH = 2,
    parameter int CNT_WIDTH  = 32,
    parameter int MISS_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_en,
    input  logic [31:0]           trig_lockout,
    input  logic                  ext_trig,
    output logic                  trig_out,
    output logic                  lockout_active,
    output logic [CNT_WIDTH-1:0]  trig_count,
    output logic [MISS_WIDTH-1:0] trig_missed
);
    typedef enum logic [1:0] {DISABLED, ARMED, LOCKOUT} state_t;

    state_t                state;
    logic [SYNC_DEPTH-1:0] sync;
    logic                  prev;
    logic                  trig_edge;
    logic [31:0]           cnt;

    assign trig_edge = sync[SYNC_DEPTH-1] & ~prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_DEPTH-2:0], ext_trig};
            prev <= sync[SYNC_DEPTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= DISABLED;
            cnt            <= '0;
            trig_out       <= 1'b0;
            lockout_active <= 1'b0;
            trig_count     <= '0;
            trig_missed    <= '0;
        end else begin
            trig_out <= 1'b0;
            // disable wins over any edge in the same cycle
            if (!spi_en) begin
                state          <= DISABLED;
                cnt            <= '0;
                lockout_active <= 1'b0;
                trig_count     <= '0;
                trig_missed    <= '0;
            end else begin
                case (state)
                    DISABLED: state <= ARMED;
                    ARMED: if (trig_edge) begin
                        trig_out   <= 1'b1;
                        trig_count <= trig_count + 1'b1;
                        cnt        <= trig_lockout;
                        if (trig_lockout != 32'd0) begin
                            state          <= LOCKOUT;
                            lockout_active <= 1'b1;
                        end
                    end
                    LOCKOUT: begin
                        cnt <= cnt - 32'd1;
                        if (trig_edge && !(&trig_missed))
                            trig_missed <= trig_missed + 1'b1;
                        if (cnt <= 32'd1) begin
                            state          <= ARMED;
                            lockout_active <= 1'b0;
                        end
                    end
                    default: state <= DISABLED;
                endcase
            end
        end
    end
endmodule
